hilo_muldiv: RTL and testbench

HILO_MULDIV -- requirements
Module: hilo_muldiv

---
 rtl/hilo_muldiv_pkg.sv | 20 ++
 rtl/muldiv_step.sv | 54 +++++
 rtl/hilo_muldiv.sv | 209 ++++++++++++++++++++
 tb/tb_hilo_muldiv.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg
// Shared definitions for the Hi/Lo multiply/divide unit:
//   - WIDTH    : operand and Hi/Lo width (only 32 is supported)
//   - STEPS    : iterations per multiply or divide (one bit per cycle)
//   - DIV0_LO  : quotient reported for a divide by zero
//   - state_t  : sequencer states
package hilo_muldiv_pkg;

  localparam int WIDTH = 32;
  localparam int STEPS = 32;
  localparam logic [WIDTH-1:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step
// Purely combinational single-iteration datapath shared by multiply and divide.
// Ports:
//   is_div     in  1       selects restoring-divide step (1) or Booth step (0)
//   acc        in  WIDTH+1 Booth partial product high part / partial remainder
//   quo        in  WIDTH   Booth multiplier (shifting) / dividend-quotient shifter
//   q_m1       in  1       Booth "Q-1" bit (unused for divide)
//   m          in  WIDTH+1 sign-extended multiplicand / zero-extended |divisor|
//   acc_next   out WIDTH+1 next acc
//   quo_next   out WIDTH   next quo
//   q_m1_next  out 1       next Q-1 bit
module muldiv_step
  import hilo_muldiv_pkg::*;
(
  input  logic             is_div,
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] quo,
  input  logic             q_m1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] quo_next,
  output logic             q_m1_next
);

  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] trial;

  always_comb begin
    // acc is one bit wider than the operands so acc +/- m cannot overflow,
    // even for the most negative multiplicand.
    case ({quo[0], q_m1})
      2'b01:   booth_sum = acc + m;
      2'b10:   booth_sum = acc - m;
      default: booth_sum = acc;
    endcase

    // Restoring step: shift the next dividend bit into the remainder and
    // try subtracting the divisor; an extra top bit makes the borrow visible.
    rem_shift = {acc[WIDTH-1:0], quo[WIDTH-1]};
    trial     = {1'b0, rem_shift} - {1'b0, m};

    if (is_div) begin
      acc_next  = trial[WIDTH+1] ? rem_shift : trial[WIDTH:0];
      quo_next  = {quo[WIDTH-2:0], ~trial[WIDTH+1]};
      q_m1_next = 1'b0;
    end else begin
      acc_next  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      quo_next  = {booth_sum[0], quo[WIDTH-1:1]};
      q_m1_next = quo[0];
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv
// Iterative signed multiply (radix-2 Booth) and divide (restoring on
// magnitudes) writing a Hi/Lo register pair, one bit per clock.
// Ports:
//   clk         in  1   clock, rising edge
//   reset       in  1   asynchronous active-high reset
//   start_mult  in  1   start signed a*b (wins over start_div)
//   start_div   in  1   start signed a/b
//   a, b        in  32  operands, sampled with the start
//   busy        out 1   operation in progress
//   done        out 1   one-cycle completion pulse
//   div0        out 1   divide-by-zero pulse (only with MULDIV_DIV0_TRAP_EN)
//   Hiout       out 32  product high word / remainder
//   Loout       out 32  product low word / quotient
// Configuration macro: MULDIV_DIV0_TRAP_EN -- when defined, a divide by zero
// finishes immediately with div0 set and Hi/Lo untouched; otherwise it runs
// the full iteration and reports Hi = a, Lo = all ones.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
`ifdef MULDIV_DIV0_TRAP_EN
  output logic             div0,
`endif
  output logic [WIDTH-1:0] Hiout,
  output logic [WIDTH-1:0] Loout
);

  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             q_m1_q, q_m1_d;
  logic [WIDTH:0]   m_q, m_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             b_zero_q, b_zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
`ifdef MULDIV_DIV0_TRAP_EN
  logic             div0_q, div0_d;
`endif

  logic [WIDTH:0]   step_acc;
  logic [WIDTH-1:0] step_quo;
  logic             step_q_m1;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             last_step;

  muldiv_step u_step (
    .is_div    (state_q == ST_DIV),
    .acc       (acc_q),
    .quo       (quo_q),
    .q_m1      (q_m1_q),
    .m         (m_q),
    .acc_next  (step_acc),
    .quo_next  (step_quo),
    .q_m1_next (step_q_m1)
  );

  // Magnitudes are taken as unsigned, so 0x80000000 maps onto itself correctly.
  assign a_mag     = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag     = b[WIDTH-1] ? (~b + 1'b1) : b;
  assign last_step = (cnt_q == 6'(STEPS - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    quo_d     = quo_q;
    q_m1_d    = q_m1_q;
    m_d       = m_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    b_zero_d  = b_zero_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
`ifdef MULDIV_DIV0_TRAP_EN
    div0_d    = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_mult) begin
          state_d = ST_MULT;
          cnt_d   = '0;
          acc_d   = '0;
          quo_d   = b;
          q_m1_d  = 1'b0;
          m_d     = {a[WIDTH-1], a};
          busy_d  = 1'b1;
        end else if (start_div) begin
`ifdef MULDIV_DIV0_TRAP_EN
          if (b == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            div0_d  = 1'b1;
          end else begin
`else
          begin
`endif
            state_d   = ST_DIV;
            cnt_d     = '0;
            acc_d     = '0;
            quo_d     = a_mag;
            q_m1_d    = 1'b0;
            m_d       = {1'b0, b_mag};
            neg_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
            neg_rem_d = a[WIDTH-1];
            b_zero_d  = (b == '0);
            busy_d    = 1'b1;
          end
        end
      end

      ST_MULT, ST_DIV: begin
        acc_d  = step_acc;
        quo_d  = step_quo;
        q_m1_d = step_q_m1;
        cnt_d  = cnt_q + 6'd1;
        if (last_step) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (state_q == ST_MULT) begin
            hi_d = step_acc[WIDTH-1:0];
            lo_d = step_quo;
          end else begin
            // Truncating division: quotient sign is the XOR of operand signs,
            // remainder follows the dividend.
            hi_d = neg_rem_q ? (~step_acc[WIDTH-1:0] + 1'b1) : step_acc[WIDTH-1:0];
            if (b_zero_q) begin
              lo_d = DIV0_LO;
            end else begin
              lo_d = neg_quo_q ? (~step_quo + 1'b1) : step_quo;
            end
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      quo_q     <= '0;
      q_m1_q    <= 1'b0;
      m_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MULDIV_DIV0_TRAP_EN
      div0_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      quo_q     <= quo_d;
      q_m1_q    <= q_m1_d;
      m_q       <= m_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      b_zero_q  <= b_zero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
`ifdef MULDIV_DIV0_TRAP_EN
      div0_q    <= div0_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign Hiout = hi_q;
  assign Loout = lo_q;
`ifdef MULDIV_DIV0_TRAP_EN
  assign div0  = div0_q;
`endif

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv
// Scoreboard bench for hilo_muldiv: every start pushes the expected Hi/Lo and
// completion cycle computed from a 64-bit arithmetic model; the done monitor
// pops and compares. Builds with or without MULDIV_DIV0_TRAP_EN.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] Hiout;
  logic [31:0] Loout;
`ifdef MULDIV_DIV0_TRAP_EN
  logic        div0;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          doneCyc;
    logic        div0;
  } expect_t;

  expect_t     sbq[$];
  expect_t     mon;
  logic [31:0] modelHi;
  logic [31:0] modelLo;
  int          numChecks = 0;
  int          numErrors = 0;
  int          cyc = 0;

  hilo_muldiv dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
`ifdef MULDIV_DIV0_TRAP_EN
    .div0       (div0),
`endif
    .Hiout      (Hiout),
    .Loout      (Loout)
  );

  always #5 clk = ~clk;

  // Counts rising edges; at a falling edge cyc is the index of the last edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Drives one start pulse at a falling edge and records the model result.
  task automatic applyStimulus(input logic isDiv, input logic both, input logic [31:0] opA, input logic [31:0] opB);
    expect_t e;
    longint  sa;
    longint  sbv;
    longint  prod;
    longint  q;
    longint  r;
    @(negedge clk);
    a          = opA;
    b          = opB;
    start_mult = !isDiv || both;
    start_div  = isDiv || both;
    sa  = longint'($signed(opA));
    sbv = longint'($signed(opB));
    e.div0 = 1'b0;
    if (!isDiv || both) begin
      prod      = sa * sbv;
      e.hi      = prod[63:32];
      e.lo      = prod[31:0];
      e.doneCyc = cyc + 33;
    end else if (opB == 32'd0) begin
`ifdef MULDIV_DIV0_TRAP_EN
      e.hi      = modelHi;
      e.lo      = modelLo;
      e.div0    = 1'b1;
      e.doneCyc = cyc + 1;
`else
      e.hi      = opA;
      e.lo      = 32'hFFFF_FFFF;
      e.doneCyc = cyc + 33;
`endif
    end else begin
      q         = sa / sbv;
      r         = sa % sbv;
      e.hi      = r[31:0];
      e.lo      = q[31:0];
      e.doneCyc = cyc + 33;
    end
    modelHi = e.hi;
    modelLo = e.lo;
    sbq.push_back(e);
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
  endtask

  task automatic waitIdle(input int maxCycles);
    int n = 0;
    while (sbq.size() != 0 && n < maxCycles) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sbq.size() != 0) begin
      checkOutput("timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
  endtask

  // Completion monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sbq.size() == 0) begin
        checkOutput("spurious_done", 64'd1, 64'd0);
      end else begin
        mon = sbq.pop_front();
        checkOutput("done_cycle", 64'(cyc), 64'(mon.doneCyc));
        checkOutput("hi", 64'(Hiout), 64'(mon.hi));
        checkOutput("lo", 64'(Loout), 64'(mon.lo));
        checkOutput("busy_at_done", 64'(busy), 64'd0);
`ifdef MULDIV_DIV0_TRAP_EN
        checkOutput("div0", 64'(div0), 64'(mon.div0));
`endif
      end
    end
  end

  initial begin
    reset      = 1'b1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    a          = '0;
    b          = '0;
    modelHi    = '0;
    modelLo    = '0;
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_hi", 64'(Hiout), 64'd0);
    checkOutput("reset_lo", 64'(Loout), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 7 * -3 with busy window checks
    applyStimulus(1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD);
    checkOutput("busy_first", 64'(busy), 64'd1);
    checkOutput("hi_hold_first", 64'(Hiout), 64'd0);
    repeat (31) @(negedge clk);
    checkOutput("busy_last", 64'(busy), 64'd1);
    checkOutput("done_early", 64'(done), 64'd0);
    waitIdle(40);

    // Signed divides, including the wrap case; back-to-back starts
    applyStimulus(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
    waitIdle(40);
    applyStimulus(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIdle(40);

    // Most-negative squared; a stray start_div at N+5 must be ignored
    applyStimulus(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000);
    repeat (4) @(negedge clk);
    a         = 32'd123;
    b         = 32'd4;
    start_div = 1'b1;
    @(negedge clk);
    start_div = 1'b0;
    checkOutput("lo_hold_mid", 64'(Loout), 64'h8000_0000);
    waitIdle(40);

    // Simultaneous starts: multiply wins
    applyStimulus(1'b0, 1'b1, 32'd6, 32'd3);
    waitIdle(40);

    // Divide by zero
    applyStimulus(1'b1, 1'b0, 32'd5, 32'd0);
    waitIdle(40);

    // Sign combinations for truncating division
    applyStimulus(1'b1, 1'b0, 32'hFFFF_FFF7, 32'd4);
    waitIdle(40);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(i[0], 1'b0, $urandom, $urandom);
      waitIdle(40);
    end

    applyStimulus(1'b1, 1'b0, 32'd9, 32'hFFFF_FFFC);
    waitIdle(40);
    checkOutput("lo_before_reset", 64'(Loout), 64'hFFFF_FFFE);

    // Reset in the middle of a divide: immediate clear, no done afterwards
    applyStimulus(1'b1, 1'b0, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_hi", 64'(Hiout), 64'd0);
    checkOutput("abort_lo", 64'(Loout), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    sbq.delete();
    modelHi = '0;
    modelLo = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("post_abort_lo", 64'(Loout), 64'd0);

    // First operation after reset
    applyStimulus(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitIdle(40);

    $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
    $finish;
  end

endmodule
